wrr_arbiter: RTL and testbench

WRR_ARBITER -- requirements
Module: wrr_arbiter

---
 rtl/wrr_pkg.sv | 16 +
 rtl/wrr_arbiter_rr_pick.sv | 34 +++
 rtl/wrr_arbiter.sv | 125 ++++++++++++
 tb/tb_wrr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// wrr_pkg: shared types and constants for the
// weighted round-robin arbiter and its picker.
package wrr_pkg;

    localparam int DEF_N  = 3;
    localparam int DEF_WW = 4;

    // A stored weight of zero still grants one beat.
    localparam int ZERO_WEIGHT_LOAD = 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// rr_pick: rotating-priority search, first request
// strictly after the pointer, wrapping at N.
module rr_pick
    import wrr_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic [IW-1:0] w_cand;

    // Scan offsets 1..N from the pointer; keep the first hit.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        w_cand   = '0;
        for (int d = 1; d <= N; d++) begin
            w_cand = IW'((int'(i_ptr) + d) % N);
            if (!o_vld && i_req[w_cand]) begin
                o_vld            = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter; an owner
// keeps the grant for up to weight[owner] beats.
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int WW = DEF_WW,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req_vld,
    input  logic [N-1:0]  req_last,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [WW-1:0] cfg_weight,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_owner,
    output logic          o_busy
);

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_owner, w_owner_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [WW-1:0] r_credit, w_credit_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [WW-1:0] r_weight [N];

    logic [N-1:0]  w_pick_oh;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_vld;
    logic [WW-1:0] w_pick_wt;
    logic [WW-1:0] w_load;
    logic          w_beat;
    logic          w_last;
    logic          w_release;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req    (req_vld),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    // Arbitration reads the registered weight, so a same-cycle
    // write only affects later grants.
    assign w_pick_wt = r_weight[w_pick_idx];
    assign w_load    = (w_pick_wt == '0) ? WW'(ZERO_WEIGHT_LOAD)
                                         : w_pick_wt;
    assign w_beat    = req_vld[r_owner];
    assign w_last    = req_last[r_owner];
    assign w_release = !en || !w_beat || w_last
                       || (r_credit == WW'(1));

    // Next-state and next-output decision for IDLE/GRANT.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        w_grant_nxt  = r_grant;
        unique case (r_state)
            S_IDLE: begin
                if (en && w_pick_vld) begin
                    w_state_nxt  = S_GRANT;
                    w_owner_nxt  = w_pick_idx;
                    w_credit_nxt = w_load;
                    w_grant_nxt  = w_pick_oh;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt  = S_IDLE;
                    w_ptr_nxt    = r_owner;
                    w_credit_nxt = '0;
                    w_grant_nxt  = '0;
                end else begin
                    w_credit_nxt = r_credit - WW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, owner, pointer, credit and grant registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_ptr    <= IW'(N - 1);
            r_credit <= '0;
            r_grant  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
            r_grant  <= w_grant_nxt;
        end
    end

    // Weight table; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_weight[i] <= WW'(1);
            end
        end else if (cfg_we && (int'(cfg_idx) < N)) begin
            r_weight[cfg_idx] <= cfg_weight;
        end
    end

    assign o_grant = r_grant;
    assign o_owner = r_owner;
    assign o_busy  = (r_state == S_GRANT);

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: directed scenarios plus a random run,
// all checked against a beat-counting reference model.
module tb_wrr_arbiter;

    localparam int N  = 3;
    localparam int WW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  req_vld;
    logic [N-1:0]  req_last;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [WW-1:0] cfg_weight;
    logic [N-1:0]  o_grant;
    logic [IW-1:0] o_owner;
    logic          o_busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_used;
    int m_lim;
    int m_wt [N];

    logic [2:0] exp032 [7]  = '{3'b001, 3'b000, 3'b010, 3'b000,
                                3'b100, 3'b000, 3'b001};
    logic [2:0] exp033 [11] = '{3'b001, 3'b001, 3'b001, 3'b001,
                                3'b000, 3'b010, 3'b010, 3'b000,
                                3'b100, 3'b000, 3'b001};
    logic [2:0] exp036 [7]  = '{3'b001, 3'b001, 3'b001, 3'b001,
                                3'b000, 3'b001, 3'b000};

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_vld    (req_vld),
        .req_last   (req_last),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight),
        .o_grant    (o_grant),
        .o_owner    (o_owner),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g = '0;
        if (m_busy) g[m_owner] = 1'b1;
        return g;
    endfunction

    // One rising edge of the model, from the spec's rules.
    task automatic model_edge();
        if (rst) begin
            m_busy  = 0;
            m_owner = 0;
            m_ptr   = N - 1;
            m_used  = 0;
            m_lim   = 0;
            for (int i = 0; i < N; i++) m_wt[i] = 1;
        end else begin
            if (!m_busy) begin
                if (en && req_vld != '0) begin
                    bit found = 0;
                    for (int d = 1; d <= N; d++) begin
                        int k = (m_ptr + d) % N;
                        if (!found && req_vld[k]) begin
                            found   = 1;
                            m_owner = k;
                        end
                    end
                    m_busy = 1;
                    m_used = 0;
                    m_lim  = (m_wt[m_owner] == 0) ? 1 : m_wt[m_owner];
                end
            end else if (!en || !req_vld[m_owner]) begin
                m_busy = 0;
                m_ptr  = m_owner;
            end else begin
                m_used++;
                if (req_last[m_owner] || m_used >= m_lim) begin
                    m_busy = 0;
                    m_ptr  = m_owner;
                end
            end
            if (cfg_we && int'(cfg_idx) < N)
                m_wt[cfg_idx] = int'(cfg_weight);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("grant", 32'(o_grant), 32'(m_grant()));
        chk("busy", 32'(o_busy), 32'(m_busy));
        if (m_busy) chk("owner", 32'(o_owner), 32'(m_owner));
        chk("onehot", 32'($countones(o_grant) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        req_vld  = '0;
        req_last = '0;
        cfg_we   = 1'b0;
        step();
        rst      = 1'b0;
    endtask

    task automatic set_wt(input int idx, input int w);
        cfg_we     = 1'b1;
        cfg_idx    = IW'(idx);
        cfg_weight = WW'(w);
        step();
        cfg_we     = 1'b0;
    endtask

    initial begin
        cfg_idx    = '0;
        cfg_weight = '0;
        do_reset();
        step();
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_owner", 32'(o_owner), 32'd0);

        // unit weights, all requesting
        en = 1'b1;
        req_vld = 3'b111;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("seq032", 32'(o_grant), 32'(exp032[i]));
        end
        req_vld = '0;
        step();

        // weights 4,2,1
        do_reset();
        set_wt(0, 4);
        set_wt(1, 2);
        set_wt(2, 1);
        en = 1'b1;
        req_vld = 3'b111;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("seq033", 32'(o_grant), 32'(exp033[i]));
        end
        req_vld = '0;
        step();

        // last beat cuts a long grant
        do_reset();
        set_wt(0, 8);
        en = 1'b1;
        req_vld = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("len034", 32'(o_grant), 32'd1);
        end
        req_last = 3'b001;
        step();
        chk("end034", 32'(o_grant), 32'd0);
        req_last = '0;
        req_vld = '0;
        step();

        // en drop releases; next winner is after owner
        do_reset();
        set_wt(1, 8);
        en = 1'b1;
        req_vld = 3'b010;
        step();
        step();
        chk("own035", 32'(o_grant), 32'b010);
        en = 1'b0;
        step();
        chk("drop035", 32'(o_grant), 32'd0);
        en = 1'b1;
        req_vld = 3'b111;
        step();
        chk("next035", 32'(o_grant), 32'b100);
        req_vld = '0;
        step();

        // weight write during grant
        do_reset();
        set_wt(0, 4);
        en = 1'b1;
        req_vld = 3'b001;
        for (int i = 0; i < 7; i++) begin
            cfg_we     = (i == 1 || i == 2);
            cfg_idx    = (i == 1) ? 2'd0 : 2'd3;
            cfg_weight = (i == 1) ? 4'd1 : 4'd9;
            step();
            chk("seq036", 32'(o_grant), 32'(exp036[i]));
        end
        cfg_we = 1'b0;
        req_vld = '0;
        step();

        // reset mid-grant
        do_reset();
        set_wt(1, 4);
        en = 1'b1;
        req_vld = 3'b010;
        step();
        step();
        chk("own037", 32'(o_grant), 32'b010);
        rst = 1'b1;
        step();
        chk("rst037", 32'(o_grant), 32'd0);
        chk("rstb037", 32'(o_busy), 32'd0);
        rst = 1'b0;
        req_vld = 3'b110;
        step();
        chk("win037", 32'(o_grant), 32'b010);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            en         = ($urandom_range(0, 9) != 0);
            req_vld    = N'($urandom);
            req_last   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cfg_we     = ($urandom_range(0, 5) == 0);
            cfg_idx    = IW'($urandom_range(0, 3));
            cfg_weight = WW'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
